// File: rtl/muldiv_pkg.sv
// Shared constants, state encoding and funct decoding for the multi-cycle multiply/divide unit.
package muldiv_pkg;

  localparam logic [5:0] FUNCT_MFHI  = 6'd16;
  localparam logic [5:0] FUNCT_MTHI  = 6'd17;
  localparam logic [5:0] FUNCT_MFLO  = 6'd18;
  localparam logic [5:0] FUNCT_MTLO  = 6'd19;
  localparam logic [5:0] FUNCT_MULT  = 6'd24;
  localparam logic [5:0] FUNCT_MULTU = 6'd25;
  localparam logic [5:0] FUNCT_DIV   = 6'd26;
  localparam logic [5:0] FUNCT_DIVU  = 6'd27;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } muldiv_state_t;

  // Funct codes that touch HI/LO and therefore must wait while an iteration runs.
  function automatic logic is_muldiv_funct(input logic [5:0] f);
    logic hit;
    case (f)
      FUNCT_MFHI, FUNCT_MTHI, FUNCT_MFLO, FUNCT_MTLO,
      FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU: hit = 1'b1;
      default:                                        hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the pipeline control (master) and the multiply/divide unit (slave).
interface muldiv_if #(
  parameter int WIDTH = 32
);

  logic             op_valid;
  logic [5:0]       funct;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] mf_data;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output op_valid, funct, src_a, src_b,
    input  busy, stall, done, mf_data, hi, lo
  );

  modport slave (
    input  op_valid, funct, src_a, src_b,
    output busy, stall, done, mf_data, hi, lo
  );

endinterface

// File: rtl/muldiv_iter.sv
// One shift-add (multiply) or restoring shift-subtract (divide) step through a single shared 2*WIDTH adder.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 mode_div,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [2*WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]     mplier,
  output logic [2*WIDTH-1:0]   acc_nxt,
  output logic [2*WIDTH-1:0]   opa_nxt,
  output logic [WIDTH-1:0]     mplier_nxt
);

  localparam int W2 = 2 * WIDTH;

  // Divide packs {remainder, quotient}; the quotient MSB shifts into the remainder each step.
  logic [WIDTH:0]  shifted_s;
  logic [W2-1:0]   add_a_s;
  logic [W2-1:0]   add_b_s;
  logic            cin_s;
  logic [W2-1:0]   sum_s;
  logic            neg_s;

  assign shifted_s = acc[W2-1:WIDTH-1];

  // Adder operand select: accumulate multiplicand, or subtract the divisor from the shifted remainder.
  always_comb begin
    add_a_s = {W2{1'b0}};
    add_b_s = {W2{1'b0}};
    cin_s   = 1'b0;
    if (mode_div) begin
      add_a_s = {{(WIDTH-1){1'b0}}, shifted_s};
      add_b_s = ~opa;
      cin_s   = 1'b1;
    end else begin
      add_a_s = acc;
      add_b_s = mplier[0] ? opa : {W2{1'b0}};
      cin_s   = 1'b0;
    end
  end

  assign sum_s = add_a_s + add_b_s + {{(W2-1){1'b0}}, cin_s};
  assign neg_s = sum_s[W2-1];

  // Next-iteration state; a negative trial difference restores the shifted remainder.
  always_comb begin
    acc_nxt    = acc;
    opa_nxt    = opa;
    mplier_nxt = mplier;
    if (mode_div) begin
      acc_nxt    = {(neg_s ? shifted_s[WIDTH-1:0] : sum_s[WIDTH-1:0]), acc[WIDTH-2:0], ~neg_s};
      opa_nxt    = opa;
      mplier_nxt = mplier;
    end else begin
      acc_nxt    = sum_s;
      opa_nxt    = {opa[W2-2:0], 1'b0};
      mplier_nxt = {1'b0, mplier[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU with HI/LO registers, MFHI/MFLO/MTHI/MTLO and a pipeline stall.
// Optional build macro MULDIV_EARLY_TERM_EN: multiply exits once the remaining multiplier bits are zero.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int W2    = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  muldiv_state_t    state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [W2-1:0]    acc_r;
  logic [W2-1:0]    opa_r;
  logic [WIDTH-1:0] mplier_r;
  logic             neg_q_r;
  logic             neg_r_r;
  logic             op_div_r;
  logic             div0_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic             busy_r;
  logic             done_r;

  logic             signed_op_s;
  logic             sign_a_s;
  logic             sign_b_s;
  logic [WIDTH-1:0] abs_a_s;
  logic [WIDTH-1:0] abs_b_s;
  logic [W2-1:0]    acc_nxt_s;
  logic [W2-1:0]    opa_nxt_s;
  logic [WIDTH-1:0] mplier_nxt_s;
  logic             mul_exit_s;
  logic [W2-1:0]    prod_s;
  logic [WIDTH-1:0] quot_s;
  logic [WIDTH-1:0] rem_s;
  logic [WIDTH-1:0] fix_hi_s;
  logic [WIDTH-1:0] fix_lo_s;
  logic [WIDTH-1:0] mf_data_s;

  // Signed ops iterate on magnitudes; the sign flags are reapplied in FIX.
  always_comb begin
    signed_op_s = (bus.funct == FUNCT_MULT) || (bus.funct == FUNCT_DIV);
    sign_a_s    = signed_op_s & bus.src_a[WIDTH-1];
    sign_b_s    = signed_op_s & bus.src_b[WIDTH-1];
    abs_a_s     = sign_a_s ? -bus.src_a : bus.src_a;
    abs_b_s     = sign_b_s ? -bus.src_b : bus.src_b;
  end

  muldiv_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .mode_div   (state_r == DIV),
    .acc        (acc_r),
    .opa        (opa_r),
    .mplier     (mplier_r),
    .acc_nxt    (acc_nxt_s),
    .opa_nxt    (opa_nxt_s),
    .mplier_nxt (mplier_nxt_s)
  );

`ifdef MULDIV_EARLY_TERM_EN
  assign mul_exit_s = (cnt_r == LAST_CNT) || (mplier_nxt_s == {WIDTH{1'b0}});
`else
  assign mul_exit_s = (cnt_r == LAST_CNT);
`endif

  // Sign correction and divide-by-zero override of the raw iteration result.
  always_comb begin
    prod_s   = neg_q_r ? -acc_r : acc_r;
    quot_s   = acc_r[WIDTH-1:0];
    rem_s    = acc_r[W2-1:WIDTH];
    fix_hi_s = prod_s[W2-1:WIDTH];
    fix_lo_s = prod_s[WIDTH-1:0];
    if (op_div_r) begin
      fix_hi_s = neg_r_r ? -rem_s : rem_s;
      if (div0_r) begin
        fix_lo_s = {WIDTH{1'b1}};
      end else begin
        fix_lo_s = neg_q_r ? -quot_s : quot_s;
      end
    end else begin
      fix_hi_s = prod_s[W2-1:WIDTH];
      fix_lo_s = prod_s[WIDTH-1:0];
    end
  end

  // Control FSM with HI/LO, busy and done registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      acc_r    <= {W2{1'b0}};
      opa_r    <= {W2{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      op_div_r <= 1'b0;
      div0_r   <= 1'b0;
      hi_r     <= {WIDTH{1'b0}};
      lo_r     <= {WIDTH{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.op_valid) begin
            case (bus.funct)
              FUNCT_MULT, FUNCT_MULTU: begin
                state_r  <= MUL;
                busy_r   <= 1'b1;
                cnt_r    <= {CNT_W{1'b0}};
                acc_r    <= {W2{1'b0}};
                opa_r    <= {{WIDTH{1'b0}}, abs_a_s};
                mplier_r <= abs_b_s;
                neg_q_r  <= sign_a_s ^ sign_b_s;
                neg_r_r  <= 1'b0;
                op_div_r <= 1'b0;
                div0_r   <= 1'b0;
              end
              FUNCT_DIV, FUNCT_DIVU: begin
                state_r  <= DIV;
                busy_r   <= 1'b1;
                cnt_r    <= {CNT_W{1'b0}};
                acc_r    <= {{WIDTH{1'b0}}, abs_a_s};
                opa_r    <= {{WIDTH{1'b0}}, abs_b_s};
                mplier_r <= {WIDTH{1'b0}};
                neg_q_r  <= sign_a_s ^ sign_b_s;
                neg_r_r  <= sign_a_s;
                op_div_r <= 1'b1;
                div0_r   <= (bus.src_b == {WIDTH{1'b0}});
              end
              FUNCT_MTHI: hi_r <= bus.src_a;
              FUNCT_MTLO: lo_r <= bus.src_a;
              default: begin
              end
            endcase
          end
        end
        MUL: begin
          acc_r    <= acc_nxt_s;
          opa_r    <= opa_nxt_s;
          mplier_r <= mplier_nxt_s;
          cnt_r    <= cnt_r + CNT_ONE;
          if (mul_exit_s) begin
            state_r <= FIX;
          end
        end
        DIV: begin
          acc_r <= acc_nxt_s;
          cnt_r <= cnt_r + CNT_ONE;
          if (cnt_r == LAST_CNT) begin
            state_r <= FIX;
          end
        end
        FIX: begin
          hi_r    <= fix_hi_s;
          lo_r    <= fix_lo_s;
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Move-from path reads the architectural registers only when no result is in flight.
  always_comb begin
    mf_data_s = {WIDTH{1'b0}};
    if (!busy_r) begin
      case (bus.funct)
        FUNCT_MFHI: mf_data_s = hi_r;
        FUNCT_MFLO: mf_data_s = lo_r;
        default:    mf_data_s = {WIDTH{1'b0}};
      endcase
    end else begin
      mf_data_s = {WIDTH{1'b0}};
    end
  end

  assign bus.stall   = bus.op_valid & busy_r & is_muldiv_funct(bus.funct);
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.mf_data = mf_data_s;
  assign bus.hi      = hi_r;
  assign bus.lo      = lo_r;

endmodule
